// File: rtl/unidad_control.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for unidad_procesadora: fetches from a
// synchronous ROM, decodes the control word and constant, and resolves branches on latched flags.
module unidad_control #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] imem_addr,
  input  logic [15:0]   imem_data,
  input  logic [3:0]    flags_in,
  output logic [15:0]   control,
  output logic [3:0]    constant_out,
  output logic          out_strobe,
  output logic [3:0]    flags_q,
  output logic          busy,
  output logic          halted
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;

  localparam logic [3:0] OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_AND = 4'h4,
                         OP_OR  = 4'h5, OP_XOR = 4'h6, OP_SHL = 4'h7, OP_SHR = 4'h8,
                         OP_IN  = 4'h9, OP_OUT = 4'hA, OP_JMP = 4'hB, OP_JZ  = 4'hC,
                         OP_JC  = 4'hD, OP_JN  = 4'hE, OP_HLT = 4'hF;

  state_t        state;
  logic [AW-1:0] pc;
  logic [15:0]   ir;

  function automatic logic [3:0] alu_code(input logic [3:0] op);
    case (op)
      OP_ADD:  return 4'b0010;
      OP_SUB:  return 4'b0101;
      OP_AND:  return 4'b1000;
      OP_OR:   return 4'b1010;
      OP_XOR:  return 4'b1100;
      default: return 4'b0000;
    endcase
  endfunction

  // Field order: {regA[2], regB[2], dest[2], we, MB, ALU[4], SH[2], MF, MD}
  function automatic logic [15:0] decode_ctrl(input logic [15:0] ins);
    logic [15:0] c;
    c = '0;
    case (ins[15:12])
      OP_LDI: c = {4'b0000, ins[11:10], 1'b1, 1'b1, 4'b0000, 2'b00, 1'b1, 1'b0};
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
              c = {ins[9:8], ins[7:6], ins[11:10], 1'b1, 1'b0, alu_code(ins[15:12]),
                   2'b00, 1'b0, 1'b0};
      OP_SHL: c = {2'b00, ins[7:6], ins[11:10], 1'b1, 1'b0, 4'b0000, 2'b10, 1'b1, 1'b0};
      OP_SHR: c = {2'b00, ins[7:6], ins[11:10], 1'b1, 1'b0, 4'b0000, 2'b01, 1'b1, 1'b0};
      OP_IN:  c = {4'b0000, ins[11:10], 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1};
      OP_OUT: c = {ins[9:8], ins[7:6], 12'h000};
      default: c = '0;
    endcase
    return c;
  endfunction

  // flags are {V,N,Z,C}
  function automatic logic jump_taken(input logic [3:0] op, input logic [3:0] fl);
    case (op)
      OP_JMP:  return 1'b1;
      OP_JZ:   return fl[1];
      OP_JC:   return fl[0];
      OP_JN:   return fl[2];
      default: return 1'b0;
    endcase
  endfunction

  // Outputs depend only on registered state, so an async reset kills an in-flight write at once
  assign imem_addr    = pc;
  assign control      = (state == EXEC) ? decode_ctrl(ir) : 16'h0000;
  assign constant_out = (state == EXEC && ir[15:12] == OP_LDI) ? ir[3:0] : 4'h0;
  assign out_strobe   = (state == EXEC && ir[15:12] == OP_OUT);
  assign busy         = (state == FETCH) || (state == DECODE) || (state == EXEC);
  assign halted       = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state <= FETCH;
            pc    <= '0;
          end
        end
        FETCH:  state <= DECODE;
        DECODE: begin
          ir    <= imem_data;
          state <= EXEC;
        end
        EXEC: begin
          if (ir[15:12] >= OP_ADD && ir[15:12] <= OP_SHR)
            flags_q <= flags_in;
          if (ir[15:12] == OP_HLT) begin
            state <= HALT;
          end else begin
            state <= FETCH;
            pc    <= jump_taken(ir[15:12], flags_q) ? ir[AW-1:0] : pc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unidad_control.sv
// Self-checking bench for unidad_control: directed instruction table, multi-cycle
// corner sequences, and randomized programs against an instruction-level reference model.
module tb_unidad_control;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [3:0]  flags_in;
  logic [15:0] control;
  logic [3:0]  constant_out;
  logic        out_strobe;
  logic [3:0]  flags_q;
  logic        busy, halted;

  logic [15:0] rom [0:255];
  int checks = 0;
  int errors = 0;

  unidad_control #(.AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr),
    .imem_data(imem_data), .flags_in(flags_in), .control(control),
    .constant_out(constant_out), .out_strobe(out_strobe), .flags_q(flags_q),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= rom[imem_addr];

  typedef struct {
    logic [15:0] ins;
    logic [3:0]  fl;
    logic [15:0] ctrl;
    logic [3:0]  cst;
    logic        stb;
    logic [3:0]  fq;
    logic [7:0]  npc;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: control word assembled field by field from the instruction's meaning
  function automatic logic [15:0] ref_ctrl(input logic [15:0] ins);
    int op, ra, rb, rd, we, mb, alu, sh, mf, md;
    op = int'(ins[15:12]);
    ra = 0; rb = 0; rd = 0; we = 0; mb = 0; alu = 0; sh = 0; mf = 0; md = 0;
    case (op)
      1: begin rd = int'(ins[11:10]); we = 1; mb = 1; mf = 1; end
      2, 3, 4, 5, 6: begin
        ra = int'(ins[9:8]); rb = int'(ins[7:6]); rd = int'(ins[11:10]); we = 1;
        alu = (op == 2) ? 2 : (op == 3) ? 5 : (op == 4) ? 8 : (op == 5) ? 10 : 12;
      end
      7: begin rb = int'(ins[7:6]); rd = int'(ins[11:10]); we = 1; sh = 2; mf = 1; end
      8: begin rb = int'(ins[7:6]); rd = int'(ins[11:10]); we = 1; sh = 1; mf = 1; end
      9: begin rd = int'(ins[11:10]); we = 1; md = 1; end
      10: begin ra = int'(ins[9:8]); rb = int'(ins[7:6]); end
      default: ;
    endcase
    return 16'(ra * 16384 + rb * 4096 + rd * 1024 + we * 512 + mb * 256 +
               alu * 16 + sh * 4 + mf * 2 + md);
  endfunction

  function automatic logic [7:0] ref_next_pc(input logic [7:0] pc, input logic [15:0] ins,
                                             input logic [3:0] fq);
    int op;
    op = int'(ins[15:12]);
    if (op == 15) return pc;
    if (op == 11 || (op == 12 && fq[1]) || (op == 13 && fq[0]) || (op == 14 && fq[2]))
      return ins[7:0];
    return 8'((int'(pc) + 1) % 256);
  endfunction

  task automatic run_instr(input logic [15:0] ins, input logic [3:0] fl, input logic [7:0] pc,
                           input logic [15:0] e_ctrl, input logic [3:0] e_cst, input logic e_stb,
                           input logic [3:0] e_fq, input logic [7:0] e_npc);
    chk("fetch_addr", imem_addr, pc);
    chk("fetch_busy", busy, 1);
    chk("fetch_ctrl", control, 0);
    rom[pc]  = ins;
    start    = 1'($urandom_range(0, 1));
    flags_in = 4'($urandom_range(0, 15));
    step;
    chk("decode_ctrl", control, 0);
    chk("decode_const", constant_out, 0);
    start    = 1'($urandom_range(0, 1));
    flags_in = 4'($urandom_range(0, 15));
    step;
    chk("exec_ctrl", control, e_ctrl);
    chk("exec_const", constant_out, e_cst);
    chk("exec_strobe", out_strobe, e_stb);
    start    = 1'($urandom_range(0, 1));
    flags_in = fl;
    step;
    start = 1'b0;
    chk("flags_q", flags_q, e_fq);
    chk("next_pc", imem_addr, e_npc);
    chk("halted", halted, ins[15:12] == 4'hF);
  endtask

  initial begin
    logic [7:0]  cur_pc, m_pc, npc;
    logic [3:0]  m_fl, nfl, fl;
    logic [15:0] ins;
    int          cnt;

    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rst_n = 1'b0; start = 1'b0; flags_in = 4'h0;
    repeat (3) step;
    chk("rst_ctrl", control, 0);
    chk("rst_const", constant_out, 0);
    chk("rst_strobe", out_strobe, 0);
    chk("rst_flags", flags_q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr", imem_addr, 0);
    rst_n = 1'b1;
    step;
    step;
    chk("idle_no_start", busy, 0);

    tbl.push_back('{16'h1405, 4'hF, 16'h0702, 4'h5, 1'b0, 4'h0, 8'h01});
    tbl.push_back('{16'h2D80, 4'h3, 16'h6E20, 4'h0, 1'b0, 4'h3, 8'h02});
    tbl.push_back('{16'hC010, 4'h0, 16'h0000, 4'h0, 1'b0, 4'h3, 8'h10});
    tbl.push_back('{16'hD020, 4'h0, 16'h0000, 4'h0, 1'b0, 4'h3, 8'h20});
    tbl.push_back('{16'hE030, 4'hF, 16'h0000, 4'h0, 1'b0, 4'h3, 8'h21});
    tbl.push_back('{16'h3140, 4'h4, 16'h5250, 4'h0, 1'b0, 4'h4, 8'h22});
    tbl.push_back('{16'h0000, 4'hF, 16'h0000, 4'h0, 1'b0, 4'h4, 8'h23});
    tbl.push_back('{16'hE040, 4'h0, 16'h0000, 4'h0, 1'b0, 4'h4, 8'h40});
    tbl.push_back('{16'h4B00, 4'h8, 16'hCA80, 4'h0, 1'b0, 4'h8, 8'h41});
    tbl.push_back('{16'h54C0, 4'h1, 16'h36A0, 4'h0, 1'b0, 4'h1, 8'h42});
    tbl.push_back('{16'h6280, 4'h2, 16'hA2C0, 4'h0, 1'b0, 4'h2, 8'h43});
    tbl.push_back('{16'h7B40, 4'h6, 16'h1A0A, 4'h0, 1'b0, 4'h6, 8'h44});
    tbl.push_back('{16'h8CC0, 4'h9, 16'h3E06, 4'h0, 1'b0, 4'h9, 8'h45});
    tbl.push_back('{16'h9400, 4'h0, 16'h0601, 4'h0, 1'b0, 4'h9, 8'h46});
    tbl.push_back('{16'hA3C0, 4'h0, 16'hF000, 4'h0, 1'b1, 4'h9, 8'h47});
    tbl.push_back('{16'h1F3A, 4'h0, 16'h0F02, 4'hA, 1'b0, 4'h9, 8'h48});
    tbl.push_back('{16'hB0FF, 4'h0, 16'h0000, 4'h0, 1'b0, 4'h9, 8'hFF});
    tbl.push_back('{16'h0000, 4'h0, 16'h0000, 4'h0, 1'b0, 4'h9, 8'h00});
    tbl.push_back('{16'hD055, 4'h0, 16'h0000, 4'h0, 1'b0, 4'h9, 8'h55});
    tbl.push_back('{16'hC077, 4'h0, 16'h0000, 4'h0, 1'b0, 4'h9, 8'h56});
    tbl.push_back('{16'hF000, 4'h0, 16'h0000, 4'h0, 1'b0, 4'h9, 8'h56});

    start = 1'b1; step; start = 1'b0;
    cur_pc = 8'h00;
    foreach (tbl[i]) begin
      run_instr(tbl[i].ins, tbl[i].fl, cur_pc, tbl[i].ctrl, tbl[i].cst, tbl[i].stb,
                tbl[i].fq, tbl[i].npc);
      cur_pc = tbl[i].npc;
    end

    // HALT holds everything regardless of live flags
    for (int i = 0; i < 20; i++) begin
      flags_in = 4'($urandom_range(0, 15));
      step;
      chk("halt_ctrl", control, 0);
      chk("halt_flags", flags_q, 4'h9);
      chk("halt_state", halted, 1);
    end

    // Demo program twice from HALT: identical timing and results
    rom[0] = 16'h1405; rom[1] = 16'h1803; rom[2] = 16'h2D80; rom[3] = 16'hA0C0; rom[4] = 16'hF000;
    flags_in = 4'h0;
    for (int r = 0; r < 2; r++) begin
      start = 1'b1; step; start = 1'b0;
      cnt = 1;
      while (!out_strobe && cnt < 40) begin step; cnt++; end
      chk("strobe_cycle", cnt, 12);
      chk("strobe_ctrl", control, 16'h3000);
      cnt = 0;
      while (!halted && cnt < 40) begin step; cnt++; end
      chk("demo_halted", halted, 1);
      chk("demo_pc", imem_addr, 4);
      chk("demo_flags", flags_q, 0);
    end

    // Reset during EXEC of LDI r2,9
    rom[0] = 16'h1809;
    start = 1'b1; step; start = 1'b0;
    step; step;
    chk("ldi_exec_ctrl", control, 16'h0B02);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ctrl", control, 0);
    chk("async_const", constant_out, 0);
    chk("async_busy", busy, 0);
    chk("async_addr", imem_addr, 0);
    chk("async_flags", flags_q, 0);
    step;
    rst_n = 1'b1;
    step;
    chk("post_rst_idle", busy, 0);
    chk("post_rst_halt", halted, 0);

    // Random programs against the instruction-level model
    start = 1'b1; step; start = 1'b0;
    m_pc = 8'h00; m_fl = 4'h0;
    repeat (300) begin
      ins = 16'($urandom);
      fl  = 4'($urandom_range(0, 15));
      nfl = (ins[15:12] >= 4'h2 && ins[15:12] <= 4'h8) ? fl : m_fl;
      npc = ref_next_pc(m_pc, ins, m_fl);
      run_instr(ins, fl, m_pc, ref_ctrl(ins), (ins[15:12] == 4'h1) ? ins[3:0] : 4'h0,
                ins[15:12] == 4'hA, nfl, npc);
      m_fl = nfl;
      m_pc = npc;
      if (ins[15:12] == 4'hF) begin
        start = 1'b1; step; start = 1'b0;
        m_pc = 8'h00;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidad_control.md
Name: unidad_control

Overview:
- Multi-cycle sequencer that fetches 16-bit instructions from a synchronous instruction ROM.
- Decodes each instruction into the 16-bit control word and 4-bit constant of unidad_procesadora, and drives them.
- Latches the datapath flags and resolves conditional jumps.
- Sits between program memory and unidad_procesadora, replacing bench-driven control words.

Parameters:
AW, 8, instruction-memory address width (PC width).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin execution at PC=0; honoured only in IDLE or HALT.
imem_addr  out  AW  instruction address (equals PC).
imem_data  in  16  instruction word, valid one cycle after imem_addr.
flags_in  in  4  datapath flags {V,N,Z,C}.
control  out  16  datapath control word {regA[2],regB[2],dest[2],we,MB,ALU[4],SH[2],MF,MD}.
constant_out  out  4  datapath Constant_IN.
out_strobe  out  1  one-cycle pulse on OUT; regB is driving dataout.
flags_q  out  4  latched {V,N,Z,C}.
busy  out  1  high in FETCH/DECODE/EXEC.
halted  out  1  high in HALT.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, PC=0, IR=0, flags_q=0, control=0, constant_out=0, out_strobe=0, busy=0, halted=0.
- FSM states:
  - IDLE: start -> FETCH.
  - FETCH: imem_addr=PC -> DECODE.
  - DECODE: IR<=imem_data -> EXEC.
  - EXEC: control/constant driven combinationally from IR for exactly this cycle -> FETCH, or -> HALT for HLT.
  - HALT: start -> FETCH with PC=0.
- Timing: 3 cycles per instruction. Outside EXEC, control=0 and constant_out=0 (we=0, so no register writes).
- IR fields: op=IR[15:12], d=IR[11:10], a=IR[9:8], b=IR[7:6], imm4=IR[3:0], tgt=IR[AW-1:0].
- ALU codes: ADD 0010, SUB 0101, AND 1000, OR 1010, XOR 1100.
- SH codes: 00 pass B, 01 shift right logical, 10 shift left.
- Opcodes (all non-listed fields 0):
  - 0 NOP: control=0.
  - 1 LDI: dest=d, we=1, MB=1, SH=00, MF=1, constant_out=imm4.
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR: regA=a, regB=b, dest=d, we=1, ALU=code, MF=0, MD=0.
  - 7 SHL / 8 SHR: regB=b, dest=d, we=1, SH=10 / 01, MF=1.
  - 9 IN: dest=d, we=1, MD=1.
  - A OUT: regA=a, regB=b, we=0; out_strobe=1 this cycle.
  - B JMP: PC<=tgt.
  - C JZ / D JC / E JN: PC<=tgt if flags_q Z / C / N =1, else PC+1.
  - F HLT: PC unchanged, -> HALT.
- PC: PC<=PC+1 at end of EXEC unless a jump is taken; wraps 2^AW-1 -> 0.
- Flag latch: flags_q<=flags_in at end of EXEC only for ops 2-8. All other ops, including branches, leave flags_q unchanged.
- Branches test flags_q, never the live flags_in.
- start in FETCH/DECODE/EXEC: ignored.
- start in same cycle as HLT decode: HLT wins; a later start is needed to restart.
- rst_n asserted mid-instruction: immediate return to reset values. An in-flight EXEC write is abandoned because control is forced to 0 asynchronously.
- imem_data is sampled only in DECODE.

Test Plan:
- Reset then start; ROM {LDI r1,5; LDI r2,3; ADD r3,r1,r2; OUT r3; HLT} -> EXEC control words 0x1_, …; out_strobe at cycle 12 after start, datapath dataout=8, flags_q=0000, halted=1 at PC=4.
- SUB r0,r1,r1 with r1=5 -> flags_q Z=1; following JZ 0x10 -> imem_addr=0x10 in next FETCH. Repeat with r1≠r0 -> falls through to PC+1.
- ADD 0xF+0x1 -> flags_q C=1,Z=1; following JC taken. A NOP between ADD and JC leaves flags_q unchanged and the jump still taken.
- PC at 0xFF executing NOP -> next imem_addr=0x00; JMP 0xFF then NOP -> wrap verified.
- rst_n pulsed low during EXEC of LDI r2,9 -> control drops to 0 in the same cycle, r2 not written, state IDLE, PC=0; start pulses while busy do not disturb the sequence.
- HALT: control stays 0 and flags_q holds for 20 cycles; start -> FETCH from PC=0 and the program reruns with identical outputs.
